// File: rtl/regfile_wb_if.sv
// Writeback and read-port bundle between the ALU side and regfile_wb.
// The write port is always ready, so there is no ready signal.
interface regfile_wb_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rd_data;
  logic [7:0]    commit_count;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_data,
    output rs1_addr,
    output rd_addr,
    input  rs1_data,
    input  rd_data,
    input  commit_count
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    input  rs1_addr,
    input  rd_addr,
    output rs1_data,
    output rd_data,
    output commit_count
  );
endinterface

// File: rtl/regfile_wb.sv
// Register file with a one-entry pending writeback slot and read bypass.
// Define REGFILE_ZERO_REG_EN to hardwire r0 to zero.
module regfile_wb #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wb_if.slave  bus
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] pend_a_q, pend_a_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          commit_en;

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    commit_en = pend_v_q && (pend_a_q != '0);
`else
    commit_en = pend_v_q;
`endif
  end

  always_comb begin
    rf_d        = rf_q;
    pend_v_d    = bus.wb_valid;
    pend_a_d    = pend_a_q;
    pend_data_d = pend_data_q;
    cnt_d       = cnt_q;
    if (bus.wb_valid) begin
      pend_a_d    = bus.wb_addr;
      pend_data_d = bus.wb_data;
    end
    // Commit the older write while the new one is captured.
    if (commit_en) begin
      rf_d[pend_a_q] = pend_data_q;
      cnt_d          = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      pend_v_q    <= 1'b0;
      pend_a_q    <= '0;
      pend_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      rf_q        <= rf_d;
      pend_v_q    <= pend_v_d;
      pend_a_q    <= pend_a_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    bus.rs1_data = rf_q[bus.rs1_addr];
    if (pend_v_q && (pend_a_q == bus.rs1_addr)) begin
      bus.rs1_data = pend_data_q;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (bus.rs1_addr == '0) begin
      bus.rs1_data = '0;
    end
`endif
  end

  always_comb begin
    bus.rd_data = rf_q[bus.rd_addr];
    if (pend_v_q && (pend_a_q == bus.rd_addr)) begin
      bus.rd_data = pend_data_q;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (bus.rd_addr == '0) begin
      bus.rd_data = '0;
    end
`endif
  end

  assign bus.commit_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb.
// Build with REGFILE_ZERO_REG_EN to cover the hardwired-r0 variant.
module tb_regfile_wb;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  regfile_wb_if #(.DW(8), .AW(2)) bus ();

  regfile_wb #(.DW(8), .NREG(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step();
    wr(2'd1, 8'h5A);
    wr(2'd2, 8'h77);
    bus.rs1_addr = 2'd2;
    bus.rd_addr  = 2'd1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rs1_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_rs1 got=%h exp=00", bus.rs1_data);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_rd got=%h exp=00", bus.rd_data);
    end
    checks++;
    if (bus.commit_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt got=%0d exp=0", bus.commit_count);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      bus.rs1_addr = 2'(a);
      bus.rd_addr  = 2'(a);
      #1;
      checks++;
      if (bus.rs1_data !== 8'h00) begin
        errors++;
        $display("FAIL post_rst_rs1 a=%0d got=%h exp=00", a, bus.rs1_data);
      end
      checks++;
      if (bus.rd_data !== 8'h00) begin
        errors++;
        $display("FAIL post_rst_rd a=%0d got=%h exp=00", a, bus.rd_data);
      end
    end
    checks++;
    if (bus.commit_count !== 8'd0) begin
      errors++;
      $display("FAIL post_rst_cnt got=%0d exp=0", bus.commit_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.rs1_addr = 2'd2;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 2'd2;
    bus.wb_data  = 8'h33;
    #1;
    checks++;
    if (bus.rs1_data !== 8'h00) begin
      errors++;
      $display("FAIL basic_T got=%h exp=00", bus.rs1_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.rs1_data !== 8'h33) begin
      errors++;
      $display("FAIL basic_T1 got=%h exp=33", bus.rs1_data);
    end
    checks++;
    if (bus.commit_count !== 8'd0) begin
      errors++;
      $display("FAIL basic_cnt_T1 got=%0d exp=0", bus.commit_count);
    end
    step();
    checks++;
    if (bus.rs1_data !== 8'h33) begin
      errors++;
      $display("FAIL basic_T2 got=%h exp=33", bus.rs1_data);
    end
    checks++;
    if (bus.commit_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_cnt got=%0d exp=1", bus.commit_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rs1_addr = 2'd1;
    wr(2'd1, 8'hFF);
    checks++;
    if (bus.rs1_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_first got=%h exp=FF", bus.rs1_data);
    end
    wr(2'd1, 8'h01);
    checks++;
    if (bus.rs1_data !== 8'h01) begin
      errors++;
      $display("FAIL b2b_second got=%h exp=01", bus.rs1_data);
    end
    step();
    step();
    checks++;
    if (bus.rs1_data !== 8'h01) begin
      errors++;
      $display("FAIL b2b_hold got=%h exp=01", bus.rs1_data);
    end
    checks++;
    if (bus.commit_count !== 8'd2) begin
      errors++;
      $display("FAIL b2b_cnt got=%0d exp=2", bus.commit_count);
    end
  endtask

  task automatic test_dual_bypass();
    logic [7:0] exp0;
`ifdef REGFILE_ZERO_REG_EN
    exp0 = 8'h00;
`else
    exp0 = 8'h89;
`endif
    do_reset();
    wr(2'd0, 8'h89);
    step();
    wr(2'd3, 8'hAA);
    bus.rs1_addr = 2'd3;
    bus.rd_addr  = 2'd3;
    #1;
    checks++;
    if (bus.rs1_data !== 8'hAA) begin
      errors++;
      $display("FAIL dual_rs1 got=%h exp=AA", bus.rs1_data);
    end
    checks++;
    if (bus.rd_data !== 8'hAA) begin
      errors++;
      $display("FAIL dual_rd got=%h exp=AA", bus.rd_data);
    end
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.rd_data !== exp0) begin
      errors++;
      $display("FAIL dual_r0 got=%h exp=%h", bus.rd_data, exp0);
    end
  endtask

  task automatic test_alu_loop();
    do_reset();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h01);
    bus.rs1_addr = 2'd1;
    bus.rd_addr  = 2'd2;
    #1;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 2'd3;
    bus.wb_data  = bus.rs1_data + bus.rd_data;
    step();
    idle();
    step();
    bus.rs1_addr = 2'd3;
    #1;
    checks++;
    if (bus.rs1_data !== 8'h00) begin
      errors++;
      $display("FAIL alu_add got=%h exp=00", bus.rs1_data);
    end
    bus.rs1_addr = 2'd1;
    bus.rd_addr  = 2'd1;
    #1;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 2'd1;
    bus.wb_data  = bus.rs1_data + bus.rd_data;
    step();
    idle();
    step();
    #1;
    checks++;
    if (bus.rs1_data !== 8'hFE) begin
      errors++;
      $display("FAIL alu_dbl got=%h exp=FE", bus.rs1_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 2'(1 + (i % 3));
      bus.wb_data  = 8'(i);
      step();
    end
    idle();
    step();
    checks++;
    if (bus.commit_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_cnt got=%0d exp=1", bus.commit_count);
    end
    bus.rs1_addr = 2'd1;
    bus.rd_addr  = 2'd2;
    #1;
    checks++;
    if (bus.rs1_data !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_r1 got=%h exp=FF", bus.rs1_data);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL wrap_r2 got=%h exp=00", bus.rd_data);
    end
    bus.rs1_addr = 2'd3;
    #1;
    checks++;
    if (bus.rs1_data !== 8'hFE) begin
      errors++;
      $display("FAIL wrap_r3 got=%h exp=FE", bus.rs1_data);
    end
`ifdef REGFILE_ZERO_REG_EN
    wr(2'd0, 8'h55);
    wr(2'd0, 8'h66);
    step();
    bus.rs1_addr = 2'd0;
    #1;
    checks++;
    if (bus.commit_count !== 8'd1) begin
      errors++;
      $display("FAIL zero_cnt got=%0d exp=1", bus.commit_count);
    end
    checks++;
    if (bus.rs1_data !== 8'h00) begin
      errors++;
      $display("FAIL zero_r0 got=%h exp=00", bus.rs1_data);
    end
`endif
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.rs1_addr = '0;
    bus.rd_addr  = '0;
    idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_dual_bypass();
    test_alu_loop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
